// File: rtl/bist_pkg.sv
// bist_pkg
//   Shared definitions for the BIST stimulus/signature controller:
//   controller state encoding, default polynomials and seeds for the s832
//   benchmark (18 PI / 19 PO, PI G18 acts as the CUT synchronous reset),
//   and a single-step helper for tap-mask shift registers (LFSR and MISR).
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } bist_state_e;

  // s832 defaults
  localparam int          S832_PI_W        = 18;
  localparam int          S832_PO_W        = 19;
  localparam logic [17:0] S832_LFSR_POLY   = 18'h20400;  // x^18+x^11+1
  localparam logic [17:0] S832_LFSR_SEED   = 18'h00001;
  localparam logic [18:0] S832_MISR_POLY   = 19'h40023;  // x^19+x^6+x^2+x+1
  localparam logic [18:0] S832_MISR_SEED   = 19'h00000;
  localparam int          S832_CUT_RST_BIT = 17;         // G18

  // One shift of a tap-mask register up to 32 bits wide: shift left by one,
  // the new LSB is the parity of the tapped bits, result truncated to w bits.
  function automatic logic [31:0] tap_step(input logic [31:0] s,
                                           input logic [31:0] poly,
                                           input int          w);
    logic [31:0] keep;
    keep = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ({s[30:0], 1'b0} | {31'd0, ^(s & poly)}) & keep;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr
//   Multiple-input signature register. Each enabled edge shifts the register
//   with tap-mask feedback and XORs in the response word.
//   Ports:
//     clk_sys - clock, state changes on the falling edge
//     rst     - synchronous active-high reset, clears the signature to 0
//     load    - load MISR_SEED (wins over enable)
//     enable  - absorb din on this edge
//     din     - response word (PO_W)
//     sig     - current signature (PO_W)
module bist_misr
  import bist_pkg::*;
#(
  parameter int               PO_W      = S832_PO_W,
  parameter logic [PO_W-1:0]  MISR_POLY = S832_MISR_POLY,
  parameter logic [PO_W-1:0]  MISR_SEED = S832_MISR_SEED
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            load,
  input  logic            enable,
  input  logic [PO_W-1:0] din,
  output logic [PO_W-1:0] sig
);

  logic [PO_W-1:0] sig_q;
  logic [PO_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = MISR_SEED;
    end else if (enable) begin
      sig_d = PO_W'(tap_step(32'(sig_q), 32'(MISR_POLY), PO_W)) ^ din;
    end
  end

  always_ff @(negedge clk_sys) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_stim_sig_ctrl.sv
// bist_stim_sig_ctrl
//   BIST driver for a sequential CUT: holds the CUT in reset for INIT_CYCLES,
//   then applies NUM_PAT pseudo-random patterns from an LFSR on STIM while a
//   MISR compacts RESP. After the last response the signature is compared
//   against GOLDEN. All state changes on the falling edge of CK, the same
//   edge the CUT flops use.
//   Ports:
//     CK        - clock (falling edge active)
//     RST       - synchronous active-high reset
//     START     - level-sampled run request, honoured in IDLE and DONE
//     NUM_PAT   - pattern count, captured when START is accepted
//     GOLDEN    - expected signature
//     RESP      - CUT primary outputs
//     STIM      - CUT primary inputs (registered)
//     BUSY      - high in INIT and RUN
//     DONE      - high in DONE
//     SIGNATURE - MISR contents
//     PASS      - DONE and SIGNATURE == GOLDEN
//
//   state | meaning
//   IDLE  | waiting for START, STIM = 0
//   INIT  | CUT reset pin asserted on STIM for INIT_CYCLES edges
//   RUN   | one LFSR pattern per cycle on STIM, MISR absorbing RESP
//   DONE  | signature frozen, STIM = 0, START restarts
module bist_stim_sig_ctrl
  import bist_pkg::*;
#(
  parameter int              PI_W        = S832_PI_W,
  parameter int              PO_W        = S832_PO_W,
  parameter logic [PI_W-1:0] LFSR_POLY   = S832_LFSR_POLY,
  parameter logic [PI_W-1:0] LFSR_SEED   = S832_LFSR_SEED,
  parameter logic [PO_W-1:0] MISR_POLY   = S832_MISR_POLY,
  parameter logic [PO_W-1:0] MISR_SEED   = S832_MISR_SEED,
  parameter int              CUT_RST_BIT = S832_CUT_RST_BIT,
  parameter int              INIT_CYCLES = 2,
  parameter bit              MASK_RST    = 1'b1
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            START,
  input  logic [15:0]     NUM_PAT,
  input  logic [PO_W-1:0] GOLDEN,
  input  logic [PO_W-1:0] RESP,
  output logic [PI_W-1:0] STIM,
  output logic            BUSY,
  output logic            DONE,
  output logic [PO_W-1:0] SIGNATURE,
  output logic            PASS
);

  localparam logic [PI_W-1:0] RST_ONEHOT = {{(PI_W-1){1'b0}}, 1'b1} << CUT_RST_BIT;
  // During RUN the CUT reset pin is held low so a random pattern cannot
  // reset the CUT mid-test; the LFSR itself keeps its full state.
  localparam logic [PI_W-1:0] RUN_MASK   = MASK_RST ? ~RST_ONEHOT : {PI_W{1'b1}};
  localparam logic [15:0]     INIT_LOAD  = (INIT_CYCLES > 0) ? 16'(INIT_CYCLES - 1) : 16'd0;

  bist_state_e     state_q, state_d;
  logic [PI_W-1:0] stim_q, stim_d;
  logic [PI_W-1:0] lfsr_q, lfsr_d;
  logic [PI_W-1:0] lfsr_step;
  logic [15:0]     pat_left_q, pat_left_d;
  logic [15:0]     init_left_q, init_left_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            misr_load;
  logic            misr_en;

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    lfsr_d      = lfsr_q;
    pat_left_d  = pat_left_q;
    init_left_d = init_left_q;
    misr_load   = 1'b0;
    misr_en     = 1'b0;
    lfsr_step   = PI_W'(tap_step(32'(lfsr_q), 32'(LFSR_POLY), PI_W));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        stim_d = '0;
        if (START) begin
          pat_left_d = NUM_PAT;
          lfsr_d     = LFSR_SEED;
          misr_load  = 1'b1;
          if (INIT_CYCLES == 0) begin
            init_left_d = '0;
            if (NUM_PAT == 16'd0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              stim_d  = LFSR_SEED & RUN_MASK;
            end
          end else begin
            init_left_d = INIT_LOAD;
            state_d     = ST_INIT;
            stim_d      = RST_ONEHOT;
          end
        end
      end

      ST_INIT: begin
        // init_left counts the INIT edges still to come after this one
        if (init_left_q == 16'd0) begin
          if (pat_left_q == 16'd0) begin
            state_d = ST_DONE;
            stim_d  = '0;
          end else begin
            state_d = ST_RUN;
            stim_d  = lfsr_q & RUN_MASK;
          end
        end else begin
          init_left_d = init_left_q - 16'd1;
        end
      end

      ST_RUN: begin
        // this edge absorbs the response to the pattern currently on STIM
        misr_en    = 1'b1;
        lfsr_d     = lfsr_step;
        pat_left_d = pat_left_q - 16'd1;
        if (pat_left_q == 16'd1) begin
          state_d = ST_DONE;
          stim_d  = '0;
        end else begin
          stim_d = lfsr_step & RUN_MASK;
        end
      end

      default: begin
        state_d = ST_IDLE;
        stim_d  = '0;
      end
    endcase

    busy_d = (state_d == ST_INIT) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(negedge CK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      stim_q      <= '0;
      lfsr_q      <= '0;
      pat_left_q  <= '0;
      init_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      lfsr_q      <= lfsr_d;
      pat_left_q  <= pat_left_d;
      init_left_q <= init_left_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  bist_misr #(
    .PO_W      (PO_W),
    .MISR_POLY (MISR_POLY),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clk_sys (CK),
    .rst     (RST),
    .load    (misr_load),
    .enable  (misr_en),
    .din     (RESP),
    .sig     (SIGNATURE)
  );

  assign STIM = stim_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = done_q && (SIGNATURE == GOLDEN);

endmodule

// File: tb/tb_bist_stim_sig_ctrl.sv
// tb_bist_stim_sig_ctrl
//   Bench for bist_stim_sig_ctrl with s832 defaults. A schedule model counts
//   edges since an accepted START and derives every output from that count;
//   a compare process checks all outputs each rising edge (DUT updates on the
//   falling edge). Directed literal checks pin the LFSR and MISR arithmetic.
module tb_bist_stim_sig_ctrl;

  localparam int          INIT       = 2;
  localparam logic [17:0] L_POLY     = 18'h20400;
  localparam logic [17:0] L_SEED     = 18'h00001;
  localparam logic [18:0] M_POLY     = 19'h40023;
  localparam logic [18:0] M_SEED     = 19'h00000;
  localparam logic [17:0] ONEHOT     = 18'h20000;
  localparam logic [17:0] RUN_MASK   = 18'h1FFFF;
  localparam int          TBL_N      = 1100;

  logic        CK;
  logic        RST;
  logic        START;
  logic [15:0] NUM_PAT;
  logic [18:0] GOLDEN;
  logic [18:0] RESP;
  logic [17:0] STIM;
  logic        BUSY;
  logic        DONE;
  logic [18:0] SIGNATURE;
  logic        PASS;

  bist_stim_sig_ctrl #(
    .PI_W(18), .PO_W(19), .LFSR_POLY(L_POLY), .LFSR_SEED(L_SEED),
    .MISR_POLY(M_POLY), .MISR_SEED(M_SEED), .CUT_RST_BIT(17),
    .INIT_CYCLES(INIT), .MASK_RST(1'b1)
  ) dut (
    .CK(CK), .RST(RST), .START(START), .NUM_PAT(NUM_PAT), .GOLDEN(GOLDEN),
    .RESP(RESP), .STIM(STIM), .BUSY(BUSY), .DONE(DONE),
    .SIGNATURE(SIGNATURE), .PASS(PASS)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference helpers ----------------
  logic [17:0] pat_tbl [TBL_N];

  function automatic logic [18:0] misr_next(input logic [18:0] s, input logic [18:0] r);
    logic fb;
    fb = ($countones(s & M_POLY) % 2) == 1;
    return ({s[17:0], 1'b0} | {18'd0, fb}) ^ r;
  endfunction

  function automatic logic [18:0] const_sig(input logic [18:0] r, input int n);
    logic [18:0] s;
    s = M_SEED;
    for (int i = 0; i < n; i++) s = misr_next(s, r);
    return s;
  endfunction

  // ---------------- schedule model ----------------
  int          m_run  = -1;   // edges since accepted START, -1 = never started
  int          m_n    = 0;
  bit          m_done = 1'b0;
  logic [18:0] m_sig  = '0;

  always @(negedge CK) begin
    if (RST) begin
      m_run  = -1;
      m_done = 1'b0;
      m_sig  = '0;
    end else if ((m_run < 0 || m_done) && START) begin
      m_run  = 0;
      m_n    = int'(NUM_PAT);
      m_sig  = M_SEED;
      m_done = 1'b0;
    end else if (m_run >= 0 && !m_done) begin
      m_run++;
      if (m_run > INIT && m_run <= INIT + m_n) m_sig = misr_next(m_sig, RESP);
      if (m_run == INIT + m_n) m_done = 1'b1;
    end
  end

  logic        e_busy;
  logic [17:0] e_stim;

  always @(posedge CK) begin
    if (chk_en) begin
      e_busy = (m_run >= 0) && !m_done;
      if (!e_busy)          e_stim = '0;
      else if (m_run < INIT) e_stim = ONEHOT;
      else                   e_stim = pat_tbl[m_run - INIT] & RUN_MASK;
      chk("stim", 32'(STIM), 32'(e_stim));
      chk("busy", 32'(BUSY), 32'(e_busy));
      chk("done", 32'(DONE), 32'(m_done));
      chk("signature", 32'(SIGNATURE), 32'(m_sig));
      chk("pass", 32'(PASS), 32'(m_done && (m_sig == GOLDEN)));
    end
  end

  // ---------------- response source ----------------
  int          resp_mode  = 0;   // 0 fixed, 1 random, 2 mock CUT
  logic [18:0] resp_fixed = '0;
  logic [18:0] cut_q      = '0;

  // Tiny sequential stand-in for the CUT: STIM[17] clears its state.
  always @(posedge CK) begin
    if (STIM[17]) cut_q <= '0;
    else          cut_q <= {cut_q[17:0], cut_q[18] ^ cut_q[5]} ^ {1'b0, STIM};
  end

  always @(posedge CK) begin
    #2;
    if (resp_mode == 1)      RESP = 19'($urandom);
    else if (resp_mode == 2) RESP = cut_q ^ {STIM[2:0], 16'd0};
    else                     RESP = resp_fixed;
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (!DONE && k < limit) begin
      tick();
      k++;
    end
    chk("done_timeout", 32'(DONE), 32'd1);
  endtask

  logic [17:0] lfsr_tbl [15];
  logic [18:0] sig_tbl  [7];
  logic [18:0] sig1;

  initial begin
    logic [17:0] p;
    p = L_SEED;
    for (int k = 0; k < TBL_N; k++) begin
      pat_tbl[k] = p;
      p = {p[16:0], ($countones(p & L_POLY) % 2) == 1};
    end
    lfsr_tbl = '{18'h20000, 18'h20000, 18'h00001, 18'h00002, 18'h00004,
                 18'h00008, 18'h00010, 18'h00020, 18'h00040, 18'h00080,
                 18'h00100, 18'h00200, 18'h00400, 18'h00801, 18'h00000};
    sig_tbl  = '{19'h0, 19'h0, 19'h0, 19'h1, 19'h2, 19'h4, 19'h9};

    RST = 1'b1; START = 1'b0; NUM_PAT = '0; GOLDEN = '0; RESP = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_stim", 32'(STIM), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sig",  32'(SIGNATURE), 32'd0);
    chk("rst_pass", 32'(PASS), 32'd0);
    RST = 1'b0;
    tick();

    // LFSR sequence, 12 patterns
    NUM_PAT = 16'd12;
    START   = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge CK);
      chk("lfsr_seq", 32'(STIM), 32'(lfsr_tbl[i]));
      if (i == 13) chk("lfsr_busy_last", 32'(BUSY), 32'd1);
      if (i == 14) chk("lfsr_done", 32'(DONE), 32'd1);
      #1 START = 1'b0;
    end

    // MISR arithmetic, restart from DONE
    resp_fixed = 19'h00001;
    GOLDEN     = 19'h00009;
    NUM_PAT    = 16'd4;
    tick();
    START = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge CK);
      chk("misr_sig", 32'(SIGNATURE), 32'(sig_tbl[i]));
      if (i == 0) begin
        chk("restart_done_drop", 32'(DONE), 32'd0);
        chk("restart_busy", 32'(BUSY), 32'd1);
      end
      if (i == 6) begin
        chk("misr_done", 32'(DONE), 32'd1);
        chk("misr_pass", 32'(PASS), 32'd1);
      end
      #1 START = 1'b0;
    end
    GOLDEN = 19'h00008;
    @(posedge CK);
    chk("misr_pass_bad_golden", 32'(PASS), 32'd0);
    chk("misr_done_held", 32'(DONE), 32'd1);
    #1;

    // Zero patterns: RESP never absorbed
    resp_fixed = 19'h5A5A5;
    NUM_PAT    = 16'd0;
    tick();
    START = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CK);
      if (i < 2) chk("zero_init_stim", 32'(STIM), 32'(ONEHOT));
      else begin
        chk("zero_done", 32'(DONE), 32'd1);
        chk("zero_sig", 32'(SIGNATURE), 32'd0);
      end
      #1 START = 1'b0;
    end

    // Reset mid-run at pattern 5, then full rerun
    resp_mode = 1;
    NUM_PAT   = 16'd12;
    START     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CK);
      #1 START = 1'b0;
    end
    chk("pat5_stim", 32'(STIM), 32'h00020);
    RST = 1'b1;
    @(posedge CK);
    chk("midrst_stim", 32'(STIM), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_sig",  32'(SIGNATURE), 32'd0);
    #1 RST = 1'b0;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(40);

    // START while busy has no effect; NUM_PAT changes ignored
    resp_mode  = 0;
    resp_fixed = 19'h12345;
    NUM_PAT    = 16'd8;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    START   = 1'b1;
    NUM_PAT = 16'd3;
    tick();
    START = 1'b0;
    wait_done(40);
    chk("busy_start_sig", 32'(SIGNATURE), 32'(const_sig(19'h12345, 8)));

    // Closed loop with mock CUT, two back-to-back 1024-pattern runs
    resp_mode = 2;
    NUM_PAT   = 16'd1024;
    START     = 1'b1;
    tick();
    START = 1'b0;
    wait_done(1100);
    sig1   = m_sig;
    GOLDEN = sig1;
    START  = 1'b1;
    tick();
    START = 1'b0;
    wait_done(1100);
    chk("loop_repeat_sig", 32'(SIGNATURE), 32'(sig1));
    chk("loop_repeat_pass", 32'(PASS), 32'd1);

    // Random traffic
    resp_mode = 1;
    for (int c = 0; c < 800; c++) begin
      START   = ($urandom_range(0, 5) == 0);
      NUM_PAT = 16'($urandom_range(0, 20));
      RST     = ($urandom_range(0, 96) == 0);
      if ($urandom_range(0, 15) == 0) GOLDEN = 19'($urandom);
      tick();
    end
    RST = 1'b0; START = 1'b0;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
